// File: rtl/timer_ctrl.sv
// Programmable down-counting timer with prescaler, register bus and level interrupt.
// Latency: rdata/irq/busy are combinational off registers; writes take effect on the next rising edge.
// Backpressure: none; the bus accepts one write per cycle unconditionally.
module timer_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  irq,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [PRESC_WIDTH-1:0] PONE = PRESC_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]  DONE = DATA_WIDTH'(1);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_LOAD   = 3'd1;
    localparam logic [2:0] A_PRESC  = 3'd2;
    localparam logic [2:0] A_COUNT  = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;

    state_t                  state_q, state_n;
    logic                    en_q, en_n;
    logic                    per_q, per_n;
    logic                    ie_q, ie_n;
    logic                    exp_q, exp_n;
    logic [DATA_WIDTH-1:0]   load_q, load_n;
    logic [DATA_WIDTH-1:0]   count_q, count_n;
    logic [PRESC_WIDTH-1:0]  presc_q, presc_n;
    logic [PRESC_WIDTH-1:0]  pcnt_q, pcnt_n;

    logic wr_ctrl, wr_load, wr_presc, wr_status;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_load   = we && (addr == A_LOAD);
    assign wr_presc  = we && (addr == A_PRESC);
    assign wr_status = we && (addr == A_STATUS);

    // Next-state and datapath: register writes first, then timer sequencing;
    // a one-shot expiry overrides a same-edge EN write, and an expiry beats a same-edge EXP clear.
    always_comb begin
        state_n = state_q;
        en_n    = en_q;
        per_n   = per_q;
        ie_n    = ie_q;
        exp_n   = exp_q;
        load_n  = load_q;
        count_n = count_q;
        presc_n = presc_q;
        pcnt_n  = pcnt_q;

        if (wr_ctrl) begin
            en_n  = wdata[0];
            per_n = wdata[1];
            ie_n  = wdata[2];
        end
        if (wr_load) begin
            load_n = wdata;
        end
        if (wr_presc) begin
            presc_n = wdata[PRESC_WIDTH-1:0];
        end
        if (wr_status && wdata[0]) begin
            exp_n = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (wr_ctrl && wdata[0]) begin
                    state_n = ARM;
                end
            end
            ARM: begin
                if (wr_ctrl && !wdata[0]) begin
                    state_n = IDLE;
                end else begin
                    count_n = load_q;
                    pcnt_n  = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (wr_ctrl && !wdata[0]) begin
                    // Stop freezes both counters where they are.
                    state_n = IDLE;
                end else if (pcnt_q != presc_q) begin
                    pcnt_n = pcnt_q + PONE;
                end else begin
                    pcnt_n = '0;
                    if (count_q != '0) begin
                        count_n = count_q - DONE;
                    end else begin
                        exp_n = 1'b1;
                        if (per_q) begin
                            count_n = load_q;
                        end else begin
                            en_n    = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and register storage, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            per_q   <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            load_q  <= '0;
            count_q <= '0;
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_n;
            en_q    <= en_n;
            per_q   <= per_n;
            ie_q    <= ie_n;
            exp_q   <= exp_n;
            load_q  <= load_n;
            count_q <= count_n;
            presc_q <= presc_n;
            pcnt_q  <= pcnt_n;
        end
    end

    // Combinational register read; unused bits and unmapped addresses read 0.
    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL:   rdata[2:0] = {ie_q, per_q, en_q};
            A_LOAD:   rdata = load_q;
            A_PRESC:  rdata[PRESC_WIDTH-1:0] = presc_q;
            A_COUNT:  rdata = count_q;
            A_STATUS: rdata[0] = exp_q;
            default:  rdata = '0;
        endcase
    end

    assign irq  = exp_q & ie_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural model of the timer's rules.
module tb_timer_ctrl;

    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          we = 1'b0;
    logic [2:0]    addr = 3'd0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          irq;
    logic          busy;

    timer_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 stopped, 1 arming, 2 counting
    int m_mode, m_load, m_presc, m_count, m_pcnt;
    bit m_en, m_per, m_ie, m_exp;

    task automatic m_reset();
        m_mode = 0; m_load = 0; m_presc = 0; m_count = 0; m_pcnt = 0;
        m_en = 0; m_per = 0; m_ie = 0; m_exp = 0;
    endtask

    function automatic int m_read(input int a);
        case (a)
            0: return {m_ie, m_per, m_en};
            1: return m_load;
            2: return m_presc;
            3: return m_count;
            4: return m_exp;
            default: return 0;
        endcase
    endfunction

    task automatic m_edge(input bit w, input int a, input logic [31:0] d);
        int  n_mode  = m_mode;
        int  n_count = m_count;
        int  n_pcnt  = m_pcnt;
        bit  expired = 0;
        bit  ctrl_w  = w && (a == 0);
        if (ctrl_w && !d[0] && m_mode != 0) begin
            n_mode = 0;
        end else if (m_mode == 1) begin
            n_count = m_load; n_pcnt = 0; n_mode = 2;
        end else if (m_mode == 2) begin
            if (m_pcnt == m_presc) begin
                n_pcnt = 0;
                if (m_count > 0) n_count = m_count - 1;
                else begin
                    expired = 1;
                    if (m_per) n_count = m_load;
                    else n_mode = 0;
                end
            end else begin
                n_pcnt = (m_pcnt + 1) % (1 << PW);
            end
        end else if (ctrl_w && d[0]) begin
            n_mode = 1;
        end
        if (ctrl_w) begin
            m_en = d[0]; m_ie = d[2];
        end
        if (expired && !m_per) m_en = 0;
        if (ctrl_w) m_per = d[1];
        if (w && a == 1) m_load  = d & ((1 << DW) - 1);
        if (w && a == 2) m_presc = d & ((1 << PW) - 1);
        if (w && a == 4 && d[0]) m_exp = 0;
        if (expired) m_exp = 1;
        m_mode = n_mode; m_count = n_count; m_pcnt = n_pcnt;
    endtask

    // One bus cycle; entered and left just after a falling edge.
    task automatic step(input bit w, input logic [2:0] a, input logic [DW-1:0] d);
        we = w; addr = a; wdata = d;
        #1;
        check("rdata", rdata, m_read(a));
        check("busy", busy, (m_mode != 0));
        check("irq", irq, (m_exp && m_ie));
        @(posedge clk);
        m_edge(w, a, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'($urandom_range(0, 7)), '0);
    endtask

    // Direct register read against a value fixed by the scenario.
    task automatic expect_reg(input string tag, input logic [2:0] a, input int want);
        we = 1'b0; addr = a;
        #1;
        check(tag, rdata, want);
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_irq", irq, 0);
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        expect_reg("reset_ctrl", 3'd0, 0);
        expect_reg("reset_count", 3'd3, 0);
        check("reset_busy", busy, 0);
        rstn = 1'b1;
        @(negedge clk);

        // One-shot: LOAD=3, PRESC=0, CTRL=IE|EN
        step(1, 3'd1, 16'd3);
        step(1, 3'd2, 16'd0);
        step(1, 3'd0, 16'b101);
        check("os_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 3'd3, '0);
            expect_reg("os_count", 3'd3, 3 - i);
        end
        step(0, 3'd4, '0);
        expect_reg("os_exp", 3'd4, 1);
        check("os_irq", irq, 1);
        expect_reg("os_ctrl", 3'd0, 3'b100);
        check("os_busy_end", busy, 0);

        // Periodic with prescaler, then clear collision with IE enabled
        do_reset();
        step(1, 3'd1, 16'd1);
        step(1, 3'd2, 16'd2);
        step(1, 3'd0, 16'b011);
        idle(6);
        expect_reg("per_exp_early", 3'd4, 0);
        step(0, 3'd4, '0);
        expect_reg("per_exp_n7", 3'd4, 1);
        check("per_irq", irq, 0);
        step(1, 3'd4, 16'd1);
        expect_reg("per_clr", 3'd4, 0);
        idle(4);
        expect_reg("per_exp_gap", 3'd4, 0);
        step(0, 3'd4, '0);
        expect_reg("per_exp_again", 3'd4, 1);
        check("per_irq2", irq, 0);
        step(1, 3'd0, 16'b111);
        idle(4);
        step(1, 3'd4, 16'd1);
        expect_reg("col_exp_set_wins", 3'd4, 1);
        check("col_irq", irq, 1);
        step(1, 3'd4, 16'd1);
        expect_reg("col_exp_clr", 3'd4, 0);
        check("col_irq_clr", irq, 0);

        // Stop with COUNT=5
        do_reset();
        step(1, 3'd1, 16'd10);
        step(1, 3'd0, 16'b001);
        idle(6);
        expect_reg("stop_pre", 3'd3, 5);
        step(1, 3'd0, 16'b000);
        check("stop_busy", busy, 0);
        idle(20);
        expect_reg("stop_count", 3'd3, 5);
        expect_reg("stop_exp", 3'd4, 0);

        // Reload only at boundary
        do_reset();
        step(1, 3'd1, 16'd10);
        step(1, 3'd0, 16'b011);
        idle(7);
        expect_reg("rl_pre", 3'd3, 4);
        step(1, 3'd1, 16'd2);
        for (int i = 0; i < 4; i++) begin
            expect_reg("rl_count", 3'd3, 3 - i);
            step(0, 3'd3, '0);
        end
        expect_reg("rl_reload", 3'd3, 2);
        expect_reg("rl_exp", 3'd4, 1);

        // Async reset mid-run
        do_reset();
        step(1, 3'd1, 16'h1234);
        step(1, 3'd2, 16'd3);
        step(1, 3'd0, 16'b111);
        idle(5);
        #2 rstn = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_irq", irq, 0);
        for (int a = 0; a < 5; a++) begin
            addr = 3'(a);
            #1;
            check("ar_reg", rdata, 0);
        end
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
        expect_reg("ar_load_after", 3'd1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom_range(0, 499) == 0) do_reset();
            r = $urandom_range(0, 99);
            if (r < 8)       step(1, 3'd0, 16'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h0));
            else if (r < 12) step(1, 3'd1, 16'($urandom_range(0, 6)));
            else if (r < 15) step(1, 3'd2, 16'($urandom_range(0, 3)));
            else if (r < 20) step(1, 3'd4, 16'($urandom));
            else if (r < 23) step(1, 3'($urandom_range(5, 7)), 16'($urandom));
            else if (r < 25) step(1, 3'd3, 16'($urandom));
            else             step(0, 3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 16, width of reload, count and bus data.
- PRESC_WIDTH, default 8, prescaler width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- we  in  1  register write strobe, one write per cycle.
- addr  in  3  register select.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  combinational read of the register at addr.
- irq  out  1  level interrupt.
- busy  out  1  high when state is not IDLE.
REQ-003 The register map SHALL be:
- 0: CTRL, read/write. bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
- 1: LOAD, read/write, full width.
- 2: PRESC, read/write, low PRESC_WIDTH bits; upper bits read 0.
- 3: COUNT, read-only; writes are ignored.
- 4: STATUS, bit0 EXP; writing 1 to bit0 clears EXP, writing 0 has no effect.
- 5-7: read 0; writes are ignored.

Function
REQ-004 The FSM SHALL have three states: IDLE, ARM and RUN.
REQ-005 IDLE -> ARM SHALL occur on the edge where a CTRL write sets EN=1.
REQ-006 ARM SHALL last exactly one cycle. At ARM exit: COUNT<=LOAD, prescaler counter<=0, state<=RUN.
REQ-007 In RUN, each edge SHALL do one of the following:
- Prescaler counter != PRESC: increment the prescaler counter.
- Prescaler counter == PRESC: set the prescaler counter to 0 and generate a tick.
REQ-008 A tick with COUNT != 0 SHALL decrement COUNT by 1.
REQ-009 A tick with COUNT == 0 is an expiry. Expiry SHALL set EXP. Then:
- PERIODIC=1: COUNT<=LOAD and the state stays RUN.
- PERIODIC=0: EN is cleared, the state goes to IDLE, and COUNT holds 0.
REQ-010 The first expiry SHALL occur at edge N+1+(LOAD+1)*(PRESC+1), where N is the EN-setting write edge. The periodic expiry interval SHALL be (LOAD+1)*(PRESC+1) cycles.
REQ-011 A CTRL write with EN=0 in ARM or RUN SHALL move the state to IDLE on that edge. COUNT holds its value and the prescaler counter holds its value.
REQ-012 A CTRL write with EN=1 while in ARM or RUN SHALL NOT restart the timer. The PERIODIC and IE fields SHALL update.
REQ-013 A LOAD write during RUN SHALL NOT change COUNT. The new value takes effect at the next ARM or periodic reload.
REQ-014 A PRESC write during RUN SHALL take effect on the next edge's comparison. If the prescaler counter exceeds the new PRESC, it SHALL keep incrementing, wrap at 2^PRESC_WIDTH, and then match.
REQ-015 An EXP clear on the same edge as an expiry SHALL leave EXP=1 (set wins).
REQ-016 If a one-shot expiry and a CTRL write with EN=1 occur on the same edge, the expiry SHALL win: EN=0 and the state is IDLE.
REQ-017 irq SHALL equal EXP AND IE, with no extra latency.
REQ-018 LOAD=0 with PRESC=0 in periodic mode SHALL expire on every cycle in RUN.
REQ-019 All arithmetic SHALL be unsigned modulo its field width, with no overflow flags.

Reset
REQ-020 While rstn=0, all of the following SHALL hold asynchronously:
- state=IDLE.
- CTRL=0, LOAD=0, PRESC=0, COUNT=0.
- Prescaler counter=0.
- EXP=0, irq=0, busy=0.
REQ-021 Reset asserted mid-operation SHALL abort immediately with no pending expiry retained.
REQ-022 After rstn deasserts, the first effective write SHALL be at the first rising edge.

Verification
REQ-023 One-shot:
- Stimulus: LOAD=3, PRESC=0, CTRL=0b101 at edge N.
- Response: busy=1 from N. COUNT reads 3,2,1,0 after edges N+1..N+4. EXP=1 and irq=1 after edge N+5. EN=0 and busy=0 after edge N+5.
REQ-024 Periodic with prescaler:
- Stimulus: LOAD=1, PRESC=2, CTRL=0b011.
- Response: EXP sets at N+7. Clear EXP, and it sets again 6 cycles later. irq stays 0 throughout (IE=0).
REQ-025 Stop:
- Stimulus: CTRL write EN=0 while COUNT=5 in RUN.
- Response: state IDLE, COUNT holds 5, no expiry afterwards.
REQ-026 Clear collision:
- Stimulus: STATUS write 1 on the expiry edge.
- Response: EXP=1.
- Stimulus: STATUS write 1 on the next edge.
- Response: EXP=0, irq=0.
REQ-027 Async reset:
- Stimulus: rstn pulled low mid-RUN between edges, with LOAD=0x1234.
- Response: all registers 0 and busy=0 without a clock edge. LOAD reads 0 after release.
REQ-028 Reload-only-at-boundary:
- Stimulus: LOAD=10 running periodic, PRESC=0; write LOAD=2 when COUNT=4.
- Response: COUNT continues 3,2,1,0. The next reload gives COUNT=2.
